vcm_af_search: RTL

// Autofocus hill-search controller; sits directly upstream of the VCM I2C writer and replaces the open-loop VCM stepper.

---
 rtl/vcm_af_pkg.sv | 29 ++
 rtl/vcm_af_search_if.sv | 27 ++
 rtl/vcm_af_wr_watchdog.sv | 30 +++
 rtl/vcm_af_search.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vcm_af_pkg.sv
// Shared types and helpers for the autofocus hill-search controller.
package vcm_af_pkg;

    localparam int POS_W = 10;
    localparam int FM_W  = 32;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WRITE     = 4'd1,
        WAIT_WR   = 4'd2,
        SETTLE    = 4'd3,
        MEASURE   = 4'd4,
        NEXT      = 4'd5,
        FINE_INIT = 4'd6,
        PARK      = 4'd7,
        DONE      = 4'd8
    } af_state_e;

    typedef enum logic [1:0] {
        COARSE  = 2'd0,
        FINE    = 2'd1,
        PARKING = 2'd2
    } af_phase_e;

    function automatic logic [15:0] vcm_pack(input logic [POS_W-1:0] code, input logic [3:0] slew);
        return {2'b00, code, slew};
    endfunction

endpackage

// File: rtl/vcm_af_search_if.sv
// Frame-measure input, VCM writer handshake and status bundle of the autofocus controller.
interface vcm_af_search_if;
    import vcm_af_pkg::*;

    logic             START;
    logic             FM_VALID;
    logic [FM_W-1:0]  FM_DATA;
    logic             WR_DONE;
    logic             WR_REQ;
    logic [15:0]      VCM_DATA;
    logic [POS_W-1:0] STEP;
    logic [FM_W-1:0]  BEST_FM;
    logic             BUSY;
    logic             LOCKED;
    logic             ERR;

    modport master (
        output START, FM_VALID, FM_DATA, WR_DONE,
        input  WR_REQ, VCM_DATA, STEP, BEST_FM, BUSY, LOCKED, ERR
    );

    modport slave (
        input  START, FM_VALID, FM_DATA, WR_DONE,
        output WR_REQ, VCM_DATA, STEP, BEST_FM, BUSY, LOCKED, ERR
    );

endinterface

// File: rtl/vcm_af_wr_watchdog.sv
// Write watchdog: counts cycles of an outstanding VCM write, pulses when the limit is reached.
module vcm_af_wr_watchdog #(
    parameter logic [31:0] WR_TIMEOUT = 32'd1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    logic [31:0] cnt_r;

    // Cycle counter: restarts on every new write, advances while the write is pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 32'd0;
        end else if (clr) begin
            cnt_r <= 32'd0;
        end else if (en) begin
            cnt_r <= cnt_r + 32'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The cycle in which the counter shows limit-1 is the limit-th pending cycle
    assign timeout = en && (cnt_r == (WR_TIMEOUT - 32'd1));

endmodule

// File: rtl/vcm_af_search.sv
// Autofocus hill-search controller: coarse sweep, fine sweep around the coarse best,
// then parks the VCM at the best focus position.
module vcm_af_search
    import vcm_af_pkg::*;
#(
    parameter logic [POS_W-1:0] POS_MIN       = 10'd0,
    parameter logic [POS_W-1:0] POS_MAX       = 10'd1023,
    parameter logic [POS_W-1:0] COARSE_STEP   = 10'd64,
    parameter logic [POS_W-1:0] FINE_STEP     = 10'd8,
    parameter logic [3:0]       SETTLE_FRAMES = 4'd2,
    parameter logic [3:0]       SLEW          = 4'h0,
    parameter logic [31:0]      WR_TIMEOUT    = 32'd1000000
) (
    input  logic           CLK_50,
    input  logic           RESET_N,
    vcm_af_search_if.slave af
);

    af_state_e              state_r, state_nxt_s;
    af_phase_e              phase_r, phase_nxt_s;
    logic [POS_W-1:0]       pos_r, pos_nxt_s;
    logic [POS_W-1:0]       hi_r, hi_nxt_s;
    logic [POS_W-1:0]       best_pos_r, best_pos_nxt_s;
    logic [POS_W-1:0]       step_r, step_nxt_s;
    logic [FM_W-1:0]        best_fm_r, best_fm_nxt_s;
    logic [3:0]             settle_cnt_r, settle_nxt_s, settle_inc_s;
    logic [15:0]            vcm_r, vcm_nxt_s;
    logic                   wr_req_r, wr_req_nxt_s;
    logic                   busy_r, busy_nxt_s;
    logic                   locked_r, locked_nxt_s;
    logic                   err_r, err_nxt_s;
    logic                   wd_clr_s, wd_en_s, wd_timeout_s;
    logic [POS_W-1:0]       step_inc_s, lo_s, fine_hi_s;
    logic [POS_W:0]         sum_s, hi_sum_s;
    logic signed [POS_W+1:0] lo_diff_s;

    vcm_af_wr_watchdog #(.WR_TIMEOUT(WR_TIMEOUT)) u_watchdog (
        .clk     (CLK_50),
        .rst_n   (RESET_N),
        .clr     (wd_clr_s),
        .en      (wd_en_s),
        .timeout (wd_timeout_s)
    );

    // Sweep arithmetic is one bit wider so the last step can be clamped to hi instead of wrapping
    assign step_inc_s   = (phase_r == COARSE) ? COARSE_STEP : FINE_STEP;
    assign sum_s        = {1'b0, pos_r} + {1'b0, step_inc_s};
    assign settle_inc_s = settle_cnt_r + 4'd1;
    assign lo_diff_s    = $signed({2'b00, best_pos_r}) - $signed({2'b00, COARSE_STEP});
    assign lo_s         = (lo_diff_s < $signed({2'b00, POS_MIN})) ? POS_MIN : lo_diff_s[POS_W-1:0];
    assign hi_sum_s     = {1'b0, best_pos_r} + {1'b0, COARSE_STEP};
    assign fine_hi_s    = (hi_sum_s > {1'b0, POS_MAX}) ? POS_MAX : hi_sum_s[POS_W-1:0];

    // Next-state and datapath decode
    always_comb begin
        state_nxt_s    = state_r;
        phase_nxt_s    = phase_r;
        pos_nxt_s      = pos_r;
        hi_nxt_s       = hi_r;
        best_pos_nxt_s = best_pos_r;
        best_fm_nxt_s  = best_fm_r;
        settle_nxt_s   = settle_cnt_r;
        step_nxt_s     = step_r;
        vcm_nxt_s      = vcm_r;
        wr_req_nxt_s   = 1'b0;
        busy_nxt_s     = busy_r;
        locked_nxt_s   = locked_r;
        err_nxt_s      = err_r;
        wd_clr_s       = 1'b0;
        wd_en_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (af.START) begin
                    pos_nxt_s      = POS_MIN;
                    hi_nxt_s       = POS_MAX;
                    phase_nxt_s    = COARSE;
                    best_fm_nxt_s  = {FM_W{1'b0}};
                    best_pos_nxt_s = POS_MIN;
                    busy_nxt_s     = 1'b1;
                    locked_nxt_s   = 1'b0;
                    err_nxt_s      = 1'b0;
                    state_nxt_s    = WRITE;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            WRITE: begin
                step_nxt_s   = pos_r;
                vcm_nxt_s    = vcm_pack(pos_r, SLEW);
                wr_req_nxt_s = 1'b1;
                wd_clr_s     = 1'b1;
                state_nxt_s  = WAIT_WR;
            end
            WAIT_WR: begin
                wd_en_s = 1'b1;
                // WR_DONE wins over a coincident FM_VALID simply because FM_VALID is not looked at here
                if (af.WR_DONE) begin
                    settle_nxt_s = 4'd0;
                    if (phase_r == PARKING) begin
                        busy_nxt_s   = 1'b0;
                        locked_nxt_s = ~err_r;
                        state_nxt_s  = DONE;
                    end else begin
                        state_nxt_s  = SETTLE;
                    end
                end else if (wd_timeout_s) begin
                    err_nxt_s    = 1'b1;
                    busy_nxt_s   = 1'b0;
                    locked_nxt_s = 1'b0;
                    state_nxt_s  = DONE;
                end else begin
                    state_nxt_s  = WAIT_WR;
                end
            end
            SETTLE: begin
                if (settle_cnt_r >= SETTLE_FRAMES) begin
                    state_nxt_s = MEASURE;
                end else if (af.FM_VALID) begin
                    settle_nxt_s = settle_inc_s;
                    if (settle_inc_s >= SETTLE_FRAMES) begin
                        state_nxt_s = MEASURE;
                    end else begin
                        state_nxt_s = SETTLE;
                    end
                end else begin
                    state_nxt_s = SETTLE;
                end
            end
            MEASURE: begin
                if (af.FM_VALID) begin
                    if (af.FM_DATA > best_fm_r) begin
                        best_fm_nxt_s  = af.FM_DATA;
                        best_pos_nxt_s = pos_r;
                    end else begin
                        best_fm_nxt_s  = best_fm_r;
                    end
                    state_nxt_s = NEXT;
                end else begin
                    state_nxt_s = MEASURE;
                end
            end
            NEXT: begin
                if (pos_r == hi_r) begin
                    if (phase_r == COARSE) begin
                        state_nxt_s = FINE_INIT;
                    end else begin
                        state_nxt_s = PARK;
                    end
                end else begin
                    pos_nxt_s   = (sum_s > {1'b0, hi_r}) ? hi_r : sum_s[POS_W-1:0];
                    state_nxt_s = WRITE;
                end
            end
            FINE_INIT: begin
                pos_nxt_s   = lo_s;
                hi_nxt_s    = fine_hi_s;
                phase_nxt_s = FINE;
                state_nxt_s = WRITE;
            end
            PARK: begin
                pos_nxt_s    = best_pos_r;
                step_nxt_s   = best_pos_r;
                vcm_nxt_s    = vcm_pack(best_pos_r, SLEW);
                wr_req_nxt_s = 1'b1;
                wd_clr_s     = 1'b1;
                phase_nxt_s  = PARKING;
                state_nxt_s  = WAIT_WR;
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            phase_r      <= COARSE;
            pos_r        <= POS_MIN;
            hi_r         <= POS_MAX;
            best_pos_r   <= POS_MIN;
            best_fm_r    <= {FM_W{1'b0}};
            settle_cnt_r <= 4'd0;
            step_r       <= {POS_W{1'b0}};
            vcm_r        <= 16'd0;
            wr_req_r     <= 1'b0;
            busy_r       <= 1'b0;
            locked_r     <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            phase_r      <= phase_nxt_s;
            pos_r        <= pos_nxt_s;
            hi_r         <= hi_nxt_s;
            best_pos_r   <= best_pos_nxt_s;
            best_fm_r    <= best_fm_nxt_s;
            settle_cnt_r <= settle_nxt_s;
            step_r       <= step_nxt_s;
            vcm_r        <= vcm_nxt_s;
            wr_req_r     <= wr_req_nxt_s;
            busy_r       <= busy_nxt_s;
            locked_r     <= locked_nxt_s;
            err_r        <= err_nxt_s;
        end
    end

    assign af.WR_REQ   = wr_req_r;
    assign af.VCM_DATA = vcm_r;
    assign af.STEP     = step_r;
    assign af.BEST_FM  = best_fm_r;
    assign af.BUSY     = busy_r;
    assign af.LOCKED   = locked_r;
    assign af.ERR      = err_r;

endmodule
